// File: rtl/layer_output_serializer.sv
// Double-buffered collector that turns one layer's parallel neuron outputs into a
// one-word-per-cycle stream, lane 0 first. Optional argmax tracker: SER_ARGMAX_EN.
module layer_output_serializer #(
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [numNeurons*dataWidth-1:0]  in_data,
    input  logic [numNeurons-1:0]            in_valid,
    input  logic                             clear_err,
    output logic [dataWidth-1:0]             out_data,
    output logic                             out_valid,
    output logic                             busy,
    output logic                             overrun,
`ifdef SER_ARGMAX_EN
    output logic [$clog2(numNeurons)-1:0]    argmax_idx,
    output logic                             argmax_valid,
`endif
    output logic                             state_dbg
);

    localparam int IW = $clog2(numNeurons);
    localparam logic [IW-1:0] LAST = IW'(numNeurons - 1);

    // Handshake: none. out_valid marks a word for exactly one cycle; the consumer
    // must take every word, there is no ready/backpressure path.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [dataWidth-1:0]   bank_q  [numNeurons];
    logic [dataWidth-1:0]   bank_d  [numNeurons];
    logic [dataWidth-1:0]   shift_q [numNeurons];
    logic [dataWidth-1:0]   shift_d [numNeurons];
    logic [numNeurons-1:0]  got_q, got_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [dataWidth-1:0]   out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   overrun_q, overrun_d;
    logic [numNeurons-1:0]  accept;
    logic                   complete;
    logic                   load;

    always_comb begin
        accept   = in_valid & ~got_q;
        // Lanes arriving this cycle count towards completion.
        complete = &(got_q | in_valid);

        bank_d = bank_q;
        got_d  = got_q | accept;
        for (int k = 0; k < numNeurons; k++) begin
            if (accept[k]) begin
                bank_d[k] = in_data[k*dataWidth +: dataWidth];
            end
        end

        // A repeated pulse on a held lane is dropped; a new overrun beats clear_err.
        if (|(in_valid & got_q)) begin
            overrun_d = 1'b1;
        end else if (clear_err) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        state_d     = state_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                if (complete) begin
                    load = 1'b1;
                end
            end
            SEND: begin
                out_valid_d = 1'b1;
                out_data_d  = shift_q[idx_q];
                if (idx_q == LAST) begin
                    if (complete) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reload uses bank_d so lanes captured this very cycle are part of the copy.
        if (load) begin
            shift_d = bank_d;
            got_d   = '0;
            idx_d   = '0;
            state_d = SEND;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            got_q       <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int k = 0; k < numNeurons; k++) begin
                bank_q[k]  <= '0;
                shift_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            got_q       <= got_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            for (int k = 0; k < numNeurons; k++) begin
                bank_q[k]  <= bank_d[k];
                shift_q[k] <= shift_d[k];
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q == SEND) | (|got_q);
    assign state_dbg = state_q;

`ifdef SER_ARGMAX_EN
    // Tracks the registered output stream, so the result lands one cycle after the last word.
    logic [IW-1:0]        out_idx_q, out_idx_d;
    logic [IW-1:0]        max_idx_q, max_idx_d;
    logic [IW-1:0]        am_idx_q, am_idx_d;
    logic [dataWidth-1:0] max_val_q, max_val_d;
    logic                 am_valid_q, am_valid_d;
    logic                 better;
    logic [IW-1:0]        cand_idx;
    logic [dataWidth-1:0] cand_val;

    always_comb begin
        out_idx_d  = (state_q == SEND) ? idx_q : out_idx_q;
        // Strict compare keeps the lower index on ties.
        better     = (out_idx_q == '0) || ($signed(out_data_q) > $signed(max_val_q));
        cand_val   = better ? out_data_q : max_val_q;
        cand_idx   = better ? out_idx_q  : max_idx_q;
        max_val_d  = max_val_q;
        max_idx_d  = max_idx_q;
        am_idx_d   = am_idx_q;
        am_valid_d = 1'b0;
        if (out_valid_q) begin
            max_val_d = cand_val;
            max_idx_d = cand_idx;
            if (out_idx_q == LAST) begin
                am_idx_d   = cand_idx;
                am_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_idx_q  <= '0;
            max_idx_q  <= '0;
            max_val_q  <= '0;
            am_idx_q   <= '0;
            am_valid_q <= 1'b0;
        end else begin
            out_idx_q  <= out_idx_d;
            max_idx_q  <= max_idx_d;
            max_val_q  <= max_val_d;
            am_idx_q   <= am_idx_d;
            am_valid_q <= am_valid_d;
        end
    end

    assign argmax_idx   = am_idx_q;
    assign argmax_valid = am_valid_q;
`endif

endmodule

// File: tb/tb_layer_output_serializer.sv
// Bench for layer_output_serializer (4 lanes): directed scenarios plus random lane
// traffic, all checked against a queue-based reference of the collect/stream rules.
module tb_layer_output_serializer;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int IW = $clog2(N);

    logic            clk;
    logic            rst;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_valid;
    logic            clear_err;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            busy;
    logic            overrun;
    logic            state_dbg;
`ifdef SER_ARGMAX_EN
    logic [IW-1:0]   argmax_idx;
    logic            argmax_valid;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    layer_output_serializer #(.numNeurons(N), .dataWidth(DW)) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .clear_err(clear_err),
        .out_data(out_data),
        .out_valid(out_valid),
        .busy(busy),
        .overrun(overrun),
`ifdef SER_ARGMAX_EN
        .argmax_idx(argmax_idx),
        .argmax_valid(argmax_valid),
`endif
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Bank: per-lane value + got. Stream: a queue of words still to be emitted and a
    // count of remaining words; a full bank moves into the queue only when the queue
    // is about to run dry (idle, or its last word goes out on this edge).
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_val[N];
    bit            m_got[N];
    int            m_rem;
    logic [DW-1:0] m_out;
    bit            m_vld;
    bit            m_ovr;
    bit            m_new_ovr;
    bit            m_all;
    int            m_am_q[$];
    bit            m_am_pend;
    bit            m_am_vld;
    int            m_am_idx;
    int            m_best;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            m_am_q.delete();
            for (int k = 0; k < N; k++) begin
                m_got[k] = 0;
                m_val[k] = '0;
            end
            m_rem = 0; m_out = '0; m_vld = 0; m_ovr = 0;
            m_am_pend = 0; m_am_vld = 0; m_am_idx = 0;
        end else begin
            m_am_vld = m_am_pend;
            if (m_am_pend) m_am_idx = m_am_q.pop_front();
            m_am_pend = 0;
            if (m_rem > 0) begin
                m_out = exp_q.pop_front();
                m_rem = m_rem - 1;
                m_vld = 1;
                if (m_rem == 0) m_am_pend = 1;
            end else begin
                m_vld = 0;
            end
            m_new_ovr = 0;
            for (int k = 0; k < N; k++) begin
                if (in_valid[k]) begin
                    if (m_got[k]) m_new_ovr = 1;
                    else begin
                        m_got[k] = 1;
                        m_val[k] = in_data[k*DW +: DW];
                    end
                end
            end
            if (m_new_ovr) m_ovr = 1;
            else if (clear_err) m_ovr = 0;
            m_all = 1;
            for (int k = 0; k < N; k++) if (!m_got[k]) m_all = 0;
            if (m_all && m_rem == 0) begin
                m_best = 0;
                for (int k = 0; k < N; k++) begin
                    exp_q.push_back(m_val[k]);
                    if ($signed(m_val[k]) > $signed(m_val[m_best])) m_best = k;
                    m_got[k] = 0;
                end
                m_am_q.push_back(m_best);
                m_rem = N;
            end
        end
    end

    function automatic bit m_busy();
        bit b;
        b = (m_rem > 0);
        for (int k = 0; k < N; k++) if (m_got[k]) b = 1;
        return b;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            n_cmp++;
            if (out_valid !== m_vld) begin
                n_bad++;
                $display("FAIL sb_valid t=%0t got=%b exp=%b", $time, out_valid, m_vld);
            end
            if (m_vld) begin
                n_cmp++;
                if (out_data !== m_out) begin
                    n_bad++;
                    $display("FAIL sb_data t=%0t got=%h exp=%h", $time, out_data, m_out);
                end
            end
            n_cmp++;
            if (overrun !== m_ovr) begin
                n_bad++;
                $display("FAIL sb_overrun t=%0t got=%b exp=%b", $time, overrun, m_ovr);
            end
            n_cmp++;
            if (busy !== m_busy()) begin
                n_bad++;
                $display("FAIL sb_busy t=%0t got=%b exp=%b", $time, busy, m_busy());
            end
`ifdef SER_ARGMAX_EN
            n_cmp++;
            if (argmax_valid !== m_am_vld) begin
                n_bad++;
                $display("FAIL sb_am_valid t=%0t got=%b exp=%b", $time, argmax_valid, m_am_vld);
            end
            n_cmp++;
            if (argmax_idx !== IW'(m_am_idx)) begin
                n_bad++;
                $display("FAIL sb_am_idx t=%0t got=%0d exp=%0d", $time, argmax_idx, m_am_idx);
            end
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_lane(input int k, input logic [DW-1:0] v);
        in_data[k*DW +: DW] = v;
    endtask

    task automatic expect_words(input string name, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                                input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        logic [DW-1:0] w[N];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== w[k]) begin
                n_bad++;
                $display("FAIL %s_word%0d got v=%b d=%h exp v=1 d=%h", name, k, out_valid, out_data, w[k]);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0; in_valid = '0; in_data = '0; clear_err = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({out_valid, out_data, busy, overrun, state_dbg} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got v=%b d=%h b=%b o=%b s=%b exp all 0",
                     out_valid, out_data, busy, overrun, state_dbg);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, busy, overrun} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_release got v=%b b=%b o=%b exp 000", out_valid, busy, overrun);
        end
    endtask

    task automatic test_simultaneous();
        for (int k = 0; k < N; k++) set_lane(k, DW'((k + 1) * 16));
        in_valid = '1;
        tick();
        in_valid = '0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL simul_latency got v=%b b=%b exp v=0 b=1", out_valid, busy);
        end
        expect_words("simul", 16'h0010, 16'h0020, 16'h0030, 16'h0040);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || state_dbg !== 1'b0) begin
            n_bad++;
            $display("FAIL simul_end got v=%b b=%b s=%b exp 0 0 0", out_valid, busy, state_dbg);
        end
    endtask

    task automatic test_out_of_order();
        int order[N];
        order[0] = 2; order[1] = 0; order[2] = 3; order[3] = 1;
        for (int i = 0; i < N; i++) begin
            set_lane(order[i], DW'(16'h0100 + order[i]));
            in_valid = '0;
            in_valid[order[i]] = 1'b1;
            tick();
            in_valid = '0;
            if (i < N - 1) begin
                @(negedge clk);
                n_cmp++;
                if (out_valid !== 1'b0 || busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL ooo_wait%0d got v=%b b=%b exp v=0 b=1", i, out_valid, busy);
                end
            end
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL ooo_latency got v=%b exp 0", out_valid);
        end
        expect_words("ooo", 16'h0100, 16'h0101, 16'h0102, 16'h0103);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] a[N];
        logic [DW-1:0] b[N];
        for (int k = 0; k < N; k++) begin
            a[k] = DW'($urandom);
            b[k] = DW'($urandom);
            set_lane(k, a[k]);
        end
        in_valid = '1;
        tick();
        for (int k = 0; k < N; k++) set_lane(k, b[k]);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_latency got v=%b exp 0", out_valid);
        end
        tick();
        in_valid = '0;
        for (int i = 0; i < 2 * N; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== (i < N ? a[i] : b[i-N])) begin
                n_bad++;
                $display("FAIL b2b_word%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data,
                         (i < N ? a[i] : b[i-N]));
            end
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_gap_end got v=%b exp 0", out_valid);
        end
    endtask

    task automatic test_overrun();
        set_lane(0, 16'h0A00); set_lane(1, 16'h1111);
        in_valid = 4'b0011;
        tick();
        set_lane(1, 16'hBEEF);
        in_valid = 4'b0010;
        tick();
        in_valid = '0;
        @(negedge clk);
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL ovr_set got=%b exp=1", overrun);
        end
        set_lane(2, 16'h0C00); set_lane(3, 16'h0D00);
        in_valid = 4'b1100;
        tick();
        in_valid = '0;
        @(negedge clk);
        expect_words("ovr", 16'h0A00, 16'h1111, 16'h0C00, 16'h0D00);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL ovr_clear got=%b exp=0", overrun);
        end
        set_lane(0, 16'h5A5A);
        in_valid = 4'b0001;
        tick();
        set_lane(0, 16'hBEEF);
        clear_err = 1'b1;
        tick();
        in_valid = '0;
        clear_err = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL ovr_set_wins got o=%b b=%b exp o=1 b=1", overrun, busy);
        end
        clear_err = 1'b1;
        for (int k = 1; k < N; k++) set_lane(k, DW'(16'h0E00 + k));
        in_valid = 4'b1110;
        tick();
        clear_err = 1'b0;
        in_valid = '0;
        @(negedge clk);
        expect_words("ovr2", 16'h5A5A, 16'h0E01, 16'h0E02, 16'h0E03);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < N; k++) set_lane(k, DW'(16'h0700 + k));
        in_valid = '1;
        tick();
        in_valid = '0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_data, busy, overrun} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid got v=%b d=%h b=%b o=%b exp all 0", out_valid, out_data, busy, overrun);
        end
        tick(); tick();
        rst = 1'b1;
        for (int k = 0; k < N; k++) set_lane(k, DW'(16'h0900 + k));
        in_valid = '1;
        tick();
        in_valid = '0;
        @(negedge clk);
        expect_words("rst_after", 16'h0900, 16'h0901, 16'h0902, 16'h0903);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_stale got v=%b b=%b exp 0 0", out_valid, busy);
        end
    endtask

`ifdef SER_ARGMAX_EN
    task automatic test_argmax();
        set_lane(0, 16'hFFF0); set_lane(1, 16'h0005);
        set_lane(2, 16'h0005); set_lane(3, 16'h8000);
        in_valid = '1;
        tick();
        in_valid = '0;
        @(negedge clk);
        expect_words("am", 16'hFFF0, 16'h0005, 16'h0005, 16'h8000);
        @(negedge clk);
        n_cmp++;
        if (argmax_valid !== 1'b1 || argmax_idx !== IW'(1)) begin
            n_bad++;
            $display("FAIL argmax_pulse got v=%b i=%0d exp v=1 i=1", argmax_valid, argmax_idx);
        end
        @(negedge clk);
        n_cmp++;
        if (argmax_valid !== 1'b0 || argmax_idx !== IW'(1)) begin
            n_bad++;
            $display("FAIL argmax_hold got v=%b i=%0d exp v=0 i=1", argmax_valid, argmax_idx);
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                set_lane(k, DW'($urandom));
                in_valid[k] = ($urandom_range(0, 9) < 3);
            end
            clear_err = ($urandom_range(0, 15) == 0);
            tick();
        end
        in_valid = '0;
        clear_err = 1'b0;
        for (int c = 0; c < 3 * N; c++) tick();
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_out_of_order();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
`ifdef SER_ARGMAX_EN
        test_argmax();
`endif
        test_random();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
